// File: rtl/ysyx_23060201_gpr_wb_arb.sv
// GPR write-back arbiter: merges EXU and LSU results into an in-order FIFO
// and drains one entry per cycle onto the GPR write port.
module ysyx_23060201_gpr_wb_arb #(
   parameter int GPR_ADDR_WIDTH = 5,
   parameter int DATA_WIDTH     = 32,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          exu_valid,
   output logic                          exu_ready,
   input  logic [GPR_ADDR_WIDTH-1:0]     exu_rd,
   input  logic [DATA_WIDTH-1:0]         exu_data,
   input  logic                          lsu_valid,
   output logic                          lsu_ready,
   input  logic [GPR_ADDR_WIDTH-1:0]     lsu_rd,
   input  logic [DATA_WIDTH-1:0]         lsu_data,
   output logic                          gpr_wen,
   output logic [GPR_ADDR_WIDTH-1:0]     gpr_waddr,
   output logic [DATA_WIDTH-1:0]         gpr_wdata,
   output logic                          wb_retire,
   output logic [2**GPR_ADDR_WIDTH-1:0]  wb_busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [GPR_ADDR_WIDTH-1:0] rd_mem   [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]     data_mem [FIFO_DEPTH];

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] exu_slot;
   logic [PW-1:0] slot;
   logic [CW-1:0] count;
   logic [CW-1:0] free;
   logic [CW-1:0] count_next;
   logic          rr_lsu;
   logic          contested;
   logic          not_empty;
   logic          lsu_push;
   logic          exu_push;
   logic          pop;

   assign free      = DEPTH_C - count;
   assign not_empty = (count != '0);

   // Free space is judged before this cycle's pop, so a full FIFO never
   // accepts even while draining; with a single slot left, round-robin decides.
   always_comb begin
      exu_ready = 1'b0;
      lsu_ready = 1'b0;
      contested = 1'b0;
      if (rst_n && !flush) begin
         if (free >= CW'(2)) begin
            exu_ready = exu_valid;
            lsu_ready = lsu_valid;
         end else if (free == CW'(1)) begin
            if (exu_valid && lsu_valid) begin
               contested = 1'b1;
               lsu_ready = rr_lsu;
               exu_ready = !rr_lsu;
            end else begin
               exu_ready = exu_valid;
               lsu_ready = lsu_valid;
            end
         end
      end
   end

   assign lsu_push   = lsu_ready;
   assign exu_push   = exu_ready;
   assign pop        = wb_retire;
   assign exu_slot   = wr_ptr + PW'(lsu_push);
   assign count_next = count + CW'(lsu_push) + CW'(exu_push) - CW'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         rr_lsu <= 1'b1;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + PW'(pop);
         wr_ptr <= wr_ptr + PW'(lsu_push) + PW'(exu_push);
         count  <= count_next;
         if (contested) rr_lsu <= !rr_lsu;
      end
   end

   // Storage is deliberately not reset; occupancy is tracked by count alone.
   always_ff @(posedge clk) begin
      if (lsu_push) begin
         rd_mem[wr_ptr]   <= lsu_rd;
         data_mem[wr_ptr] <= lsu_data;
      end
      if (exu_push) begin
         rd_mem[exu_slot]   <= exu_rd;
         data_mem[exu_slot] <= exu_data;
      end
   end

   always_comb begin
      gpr_waddr = '0;
      gpr_wdata = '0;
      if (not_empty) begin
         gpr_waddr = rd_mem[rd_ptr];
         gpr_wdata = data_mem[rd_ptr];
      end
   end

   assign wb_retire = not_empty && !flush;
   assign gpr_wen   = not_empty && !flush && (gpr_waddr != '0);

   always_comb begin
      wb_busy = '0;
      slot    = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         slot = rd_ptr + PW'(i);
         if (CW'(i) < count) wb_busy[rd_mem[slot]] = 1'b1;
      end
      wb_busy[0] = 1'b0;
   end

endmodule

// File: doc/ysyx_23060201_gpr_wb_arb.md
Name: ysyx_23060201_gpr_wb_arb

Overview:
- GPR write-back initiator: collects completed results from EXU and LSU over valid/ready handshakes, buffers them in an in-order FIFO, and drives the GPR file write port at one write per cycle.
- Exports a pending-write bitmap for hazard checks in decode.
- Exports a retire pulse per drained entry for commit and difftest.

Parameters:
- GPR_ADDR_WIDTH, 5, GPR index width; register count = 2**GPR_ADDR_WIDTH.
- DATA_WIDTH, 32, GPR data width.
- FIFO_DEPTH, 4, write-back buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous buffer flush.
- exu_valid  in  1  EXU result valid.
- exu_ready  out  1  EXU result accepted this cycle.
- exu_rd  in  GPR_ADDR_WIDTH  EXU destination register.
- exu_data  in  DATA_WIDTH  EXU result.
- lsu_valid  in  1  LSU load result valid.
- lsu_ready  out  1  LSU result accepted this cycle.
- lsu_rd  in  GPR_ADDR_WIDTH  LSU destination register.
- lsu_data  in  DATA_WIDTH  LSU load data.
- gpr_wen  out  1  GPR write enable.
- gpr_waddr  out  GPR_ADDR_WIDTH  GPR write address.
- gpr_wdata  out  DATA_WIDTH  GPR write data.
- wb_retire  out  1  one-cycle pulse per drained entry.
- wb_busy  out  2**GPR_ADDR_WIDTH  pending-write bitmap.

Behaviour:
- State:
  - FIFO of {rd, data} entries.
  - rd_ptr and wr_ptr, each log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH.
  - count, log2(FIFO_DEPTH)+1 bits.
  - rr_lsu, a 1-bit round-robin flag.
- Reset (async, rst_n=0):
  - Pointers and count cleared; rr_lsu=1 (LSU favoured first).
  - All outputs 0; FIFO storage not reset.
- Accept (combinational ready; ready may depend on valid; sources hold valid/rd/data until ready):
  - free = FIFO_DEPTH - count, measured before this cycle's pop.
  - flush=1: both readies 0.
  - free>=2: each valid source is ready.
  - free==1:
    - Only one source valid: that source is ready.
    - Both valid: rr_lsu=1 grants LSU, else EXU. rr_lsu toggles only after a contested single grant.
  - free==0: both readies 0.
  - Both accepted in one cycle: LSU entry enqueued first (slot wr_ptr), EXU entry at wr_ptr+1.
- Drain:
  - gpr_waddr = head rd and gpr_wdata = head data, driven whenever count>0, else 0.
  - gpr_wen = (count>0) && (head rd != 0) && !flush.
  - wb_retire = (count>0) && !flush.
  - Head popped at the posedge ending every cycle with wb_retire=1.
  - Latency: entry accepted at posedge k is visible on the write port in cycle k+1 at the earliest, and written into the GPR at posedge k+1.
- rd==0 entries: occupy a slot and retire normally (wb_retire=1) but never assert gpr_wen.
- Simultaneous push and pop: count += pushes - pop. The pop uses the pre-push head; an empty FIFO does not bypass input to output.
- wb_busy:
  - Bit r = 1 iff some occupied entry has rd==r.
  - Bit 0 always 0.
  - Derived from registered state only; valid in the same cycle as the FIFO contents.
- Flush (flush=1 at posedge):
  - Pointers and count cleared; rr_lsu unchanged.
  - No write or retire in the flush cycle.
  - Flush has priority over push and pop.
- Reset asserted mid-operation: immediately empties the FIFO and forces all outputs to 0, including a gpr_wen already asserted that cycle.

Test Plan:
- Reset, then EXU rd=5 data=0x1234 for one cycle -> exu_ready=1; next cycle gpr_wen=1, waddr=5, wdata=0x1234, wb_retire=1, wb_busy[5]=1; following cycle gpr_wen=0, wb_busy=0.
- EXU rd=3 and LSU rd=7 both valid in one cycle on an empty FIFO -> both ready; two consecutive write cycles, rd 7 then rd 3; wb_busy={3,7} then {3} then 0.
- Both sources held valid continuously, FIFO_DEPTH=4 -> first cycle accepts two; FIFO stays at count 3-4; contested single grants alternate LSU, EXU, LSU…; drain of exactly 1 write/cycle with no entry lost or duplicated.
- EXU rd=0 data=0xFFFF -> wb_retire pulses with gpr_wen=0; wb_busy stays 0.
- Fill to 4 entries, assert flush one cycle -> readies 0, gpr_wen=0, wb_retire=0 that cycle; next cycle count=0, wb_busy=0, no writes.
- rst_n driven low asynchronously mid-cycle while gpr_wen=1 -> gpr_wen, wb_retire and wb_busy drop to 0 without waiting for a clock edge; after release, the FIFO is empty and LSU wins the first contested grant.
